// File: rtl/mod47_lut_sched.sv
// mod47_lut_sched: sequencing controller for an external mod-47 constant-multiply LUT.
// Accepts residue operands on a valid/ready port, registers each one into lut_x,
// folds the LUT result into a mod-MOD accumulator one cycle later and presents one
// accumulated residue plus operand count per batch (batch ends on in_last).
// Optional feature: define MOD47_SCHED_RANGE_CHECK_EN to reduce out-of-range
// operands / LUT results by one subtraction of MOD and flag them on the sticky err.
module mod47_lut_sched #(
  parameter int MOD   = 47,
  parameter int W     = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic [W-1:0]     lut_x,
  input  logic [W-1:0]     lut_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // no batch open
    S_ACC   = 2'd1,  // batch open, operands streaming
    S_DRAIN = 2'd2,  // last operand sitting in the LUT stage
    S_OUT   = 2'd3   // result held for the consumer
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [W-1:0]       r_lut_x;
  logic               r_stg_v;
  logic [W-1:0]       r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_accept;
  logic               w_release;
  logic [W-1:0]       w_in_x;
  logic               w_in_err;
  logic [W-1:0]       w_z;
  logic               w_z_err;
  logic [W:0]         w_sum;
  logic [W-1:0]       w_acc_nxt;

  assign w_accept  = in_valid & r_in_ready;
  assign w_release = r_out_valid & out_ready;

  // NOTE: the range checks are compiled out entirely in the default build, so
  // the error terms collapse to constant 0 and err is a register held at reset.
`ifdef MOD47_SCHED_RANGE_CHECK_EN
  assign w_in_err = (in_data >= W'(MOD));
  assign w_in_x   = w_in_err ? (in_data - W'(MOD)) : in_data;
  assign w_z_err  = (lut_z >= W'(MOD));
  assign w_z      = w_z_err ? (lut_z - W'(MOD)) : lut_z;
`else
  assign w_in_err = 1'b0;
  assign w_in_x   = in_data;
  assign w_z_err  = 1'b0;
  assign w_z      = lut_z;
`endif

  // One extra bit keeps acc + z exact before the conditional subtraction.
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_z};
  assign w_acc_nxt = (w_sum >= (W+1)'(MOD)) ? W'(w_sum - (W+1)'(MOD)) : w_sum[W-1:0];

  // Batch FSM with registered handshake outputs.
  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            if (in_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= S_ACC;
            end
          end
        end
        S_DRAIN: begin
          r_state     <= S_OUT;
          r_out_valid <= 1'b1;
        end
        S_OUT: begin
          if (w_release) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: register the accepted operand into the LUT and mark the stage valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lut_x <= '0;
      r_stg_v <= 1'b0;
    end else begin
      r_stg_v <= w_accept;
      if (w_accept) begin
        r_lut_x <= w_in_x;
      end
    end
  end

  // Stage 2 accumulator and saturating operand counter; both clear on entry to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (r_stg_v) begin
        r_acc <= w_acc_nxt;
      end
      if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Sticky range-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((w_accept && w_in_err) || (r_stg_v && w_z_err)) begin
      r_err <= 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign lut_x     = r_lut_x;
  assign out_data  = r_acc;
  assign out_count = r_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_mod47_lut_sched.sv
// tb_mod47_lut_sched: self-checking bench for mod47_lut_sched.
// The external LUT is modelled as z = (36*x) mod 47. Directed batches come from a
// vector table; random batches are checked against a plain-arithmetic model.
module tb_mod47_lut_sched;

  localparam int MOD   = 47;
  localparam int W     = 6;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic [W-1:0]     lut_x;
  logic [W-1:0]     lut_z;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_count;
  logic             err;

  mod47_lut_sched #(.MOD(MOD), .W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .lut_x     (lut_x),
    .lut_z     (lut_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .err       (err)
  );

  // External combinational LUT.
  assign lut_z = W'((36 * int'(lut_x)) % MOD);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       n;
    logic [3:0][5:0]  ops;     // ops[0] is sent first
    logic [5:0]       exp_data;
    logic [7:0]       exp_cnt;
    logic [3:0]       stall;
  } vec_t;

  int n_cmp;
  int n_bad;
  int g_ops[$];
  bit exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lut_ref(input int x);
    return (36 * x) % MOD;
  endfunction

  function automatic int x_ref(input int x);
`ifdef MOD47_SCHED_RANGE_CHECK_EN
    return (x >= MOD) ? x - MOD : x;
`else
    return x;
`endif
  endfunction

  // Drive g_ops as one batch; called and returns at a negedge.
  task automatic send_ops(input bit bubbles, input bit open_batch);
    for (int i = 0; i < g_ops.size(); i++) begin
      if (bubbles && ($urandom_range(3) == 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = W'(g_ops[i]);
      in_last  = !open_batch && (i == g_ops.size() - 1);
      check("in_ready_open", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
`ifdef MOD47_SCHED_RANGE_CHECK_EN
      if (g_ops[i] >= MOD) exp_err = 1'b1;
`endif
      check("lut_x", lut_x, x_ref(g_ops[i]));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Entered at the negedge of the cycle after the last accept.
  task automatic get_result(input int exp_d, input int exp_c, input int stall);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 0);
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) @(negedge clk);
    check("out_valid_seen", out_valid, 1);
    check("out_data", out_data, exp_d);
    check("out_count", out_count, exp_c);
    check("err", err, exp_err);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, exp_d);
      check("stall_out_count", out_count, exp_c);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_count_clear", out_count, 0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_lut_x", lut_x, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_err", err, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_err   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // {1,2}: 36+72=108 -> 14.  46: 1656 mod 47 = 11.  0 -> 0.
    // 50: lut_z(50 or 3) = 14 either way.  {5,10,20}: 39+31+15=85 -> 38.
    vecs[0] = '{n: 4'd2, ops: {6'd0, 6'd0, 6'd2,  6'd1},  exp_data: 6'd14, exp_cnt: 8'd2, stall: 4'd0};
    vecs[1] = '{n: 4'd1, ops: {6'd0, 6'd0, 6'd0,  6'd46}, exp_data: 6'd11, exp_cnt: 8'd1, stall: 4'd0};
    vecs[2] = '{n: 4'd1, ops: {6'd0, 6'd0, 6'd0,  6'd0},  exp_data: 6'd0,  exp_cnt: 8'd1, stall: 4'd0};
    vecs[3] = '{n: 4'd3, ops: {6'd0, 6'd20, 6'd10, 6'd5}, exp_data: 6'd38, exp_cnt: 8'd3, stall: 4'd5};
    vecs[4] = '{n: 4'd1, ops: {6'd0, 6'd0, 6'd0,  6'd50}, exp_data: 6'd14, exp_cnt: 8'd1, stall: 4'd0};

    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    // Directed table: back-to-back operands, single-operand batches, stall, range.
    foreach (vecs[v]) begin
      g_ops.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) g_ops.push_back(int'(vecs[v].ops[i]));
      send_ops(1'b0, 1'b0);
      get_result(int'(vecs[v].exp_data), int'(vecs[v].exp_cnt), int'(vecs[v].stall));
    end
    // err stays at its sticky value across a further clean batch.
    g_ops = '{3};
    send_ops(1'b0, 1'b0);
    get_result(lut_ref(3), 1, 0);
    check("err_sticky", err, exp_err);

    // Random batches against the arithmetic model.
    for (int b = 0; b < 25; b++) begin
      int n;
      int sum;
      n = $urandom_range(1, 9);
      g_ops.delete();
      sum = 0;
      for (int i = 0; i < n; i++) begin
        g_ops.push_back($urandom_range(0, MOD - 1));
        sum += lut_ref(g_ops[i]);
      end
      send_ops(1'b1, 1'b0);
      get_result(sum % MOD, n, $urandom_range(0, 3));
    end

    // Reset in the middle of an open batch, then a fresh batch {2}.
    g_ops = '{3, 4, 5};
    send_ops(1'b0, 1'b1);
    pulse_reset();
    g_ops = '{2};
    send_ops(1'b0, 1'b0);
    get_result(25, 1, 0);

    // Counter saturation: 300 ones -> count 255, data (300*36) mod 47 = 37.
    g_ops.delete();
    for (int i = 0; i < 300; i++) g_ops.push_back(1);
    send_ops(1'b0, 1'b0);
    get_result(37, 255, 0);

    // Reset while the result is held.
    g_ops = '{7, 8};
    send_ops(1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1);
    pulse_reset();
    g_ops = '{9};
    send_ops(1'b0, 1'b0);
    get_result(lut_ref(9), 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mod47_lut_sched.md
# mod47_lut_sched

Sequencing controller for the 6-bit constant-multiply residue LUTs of the mod-47 datapath. Accepts a stream of residue operands on a valid/ready port and drives each operand into an external combinational LUT. It accumulates the LUT outputs modulo 47 and emits one accumulated residue per batch, where a batch is terminated by `in_last`. It sits between the operand source and the result consumer, making a bare combinational LUT usable as a pipelined multiply-accumulate stage.

## Interface
Parameters:
- `MOD`, 47: modulus; all residues are in 0..MOD-1.
- `W`, 6: residue width.
- `CNT_W`, 8: batch operand counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: operand accepted when `in_valid & in_ready`.
- `in_data` in W: operand residue.
- `in_last` in 1: operand is the final one of its batch.
- `lut_x` out W: registered operand presented to the external LUT.
- `lut_z` in W: combinational LUT result for `lut_x`, sampled the cycle after `lut_x` is loaded.
- `out_valid` out 1: batch result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out W: accumulated residue mod MOD.
- `out_count` out CNT_W: number of operands in the batch, saturating at 2^CNT_W-1.
- `err` out 1: sticky range-error flag, cleared only by `rst`.

## Operation
- FSM states:
  - IDLE: no batch open.
  - ACC: batch open.
  - DRAIN: last operand in LUT stage.
  - OUT: result held.
- Transitions:
  - IDLE→ACC on accept with `in_last`=0.
  - IDLE/ACC→DRAIN on accept with `in_last`=1.
  - ACC→ACC on accept with `in_last`=0.
  - DRAIN→OUT unconditionally.
  - OUT→IDLE on `out_valid & out_ready`.
- `in_ready` = 1 in IDLE and ACC, 0 in DRAIN and OUT.
- Stage 1 (accept cycle t): operand registered into `lut_x`, a stage-valid bit is set, and the counter is incremented with saturation.
- Stage 2 (cycle t+1): `sum = acc + lut_z` computed in W+1 bits.
  - If `sum` ≥ MOD, `acc` ← `sum`-MOD; otherwise `acc` ← `sum`.
  - `lut_z` ≥ MOD sets `err` and is treated as `lut_z`-MOD before the add.
- The first operand of a batch adds to `acc`=0. `acc` and the counter clear on entry to IDLE.
- In OUT: `out_data` = `acc` and `out_count` = counter, both held stable until the handshake.
- Back-to-back operands are accepted every cycle in IDLE/ACC with no bubbles.
- A batch of a single operand is legal: its `in_last` arrives with the first operand.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `lut_x`=0, `out_data`=0, `out_count`=0, `err`=0.
  - FSM=IDLE, `acc`=0.
- Latency: last operand accepted at cycle t → `out_valid`=1 at cycle t+2.
- Throughput: one operand per cycle within a batch. A minimum of 2 cycles of `in_ready`=0 follows each batch, plus any `out_ready` stall.
- `out_valid` stays 1 until `out_ready`; `out_valid`/`out_data` never change while stalled.
- `rst` asserted mid-batch or in OUT discards all state immediately. The first accept after deassertion starts a fresh batch.
- Counter saturation: after 255 operands, `out_count` stays 255 and the accumulation remains exact.

## Configuration
- `MOD47_SCHED_RANGE_CHECK_EN` defined:
  - An operand with `in_data` ≥ MOD is reduced by a single subtraction of MOD before loading `lut_x` (63→16), and sets `err`.
  - The `lut_z` check above is also active.
- Not defined:
  - `in_data` is passed to `lut_x` unmodified and `lut_z` is added without checking.
  - The modular reduction of `acc` is unchanged.
  - `err` is tied to 0.

## Test plan
Bench LUT model: z = (36·x) mod 47.
- Batch {1, 2(last)} back-to-back → `out_valid` 2 cycles after last accept; `out_data`=14, `out_count`=2, `err`=0.
- Single operand 46 with `in_last` → `out_data`=11, `out_count`=1. Next batch {0(last)} → `out_data`=0.
- `out_ready` held 0 for 5 cycles after the result → `out_data`/`out_count` stable, `in_ready`=0 throughout, returns to IDLE on the handshake cycle.
- With `MOD47_SCHED_RANGE_CHECK_EN` defined: operand 50(last) → `lut_x`=3, `out_data`=14, `err`=1 and remaining 1 across following batches until `rst`.
- `rst` pulsed after 3 operands of an open batch → all outputs at reset values. Batch {2(last)} → `out_data`=25, `out_count`=1.
- 300 operands of value 1 → `out_count`=255, `out_data`=(300·36) mod 47 = 37.
